video_timing_rx: RTL

- Receive-side counterpart to the 480p display timing generator. Takes negative-polarity hsync/vsync plus de and recovers the pixel position.
- Measures line period, frame line count and active area, and flags lock when timing is stable.
- Sits on capture/loopback paths and in test benches as a self-checking monitor for any timing source in the clk_pix domain.

---
 rtl/video_timing_rx.sv | 127 ++++++++++++
 1 files changed

// File: rtl/video_timing_rx.sv
// video_timing_rx: recovers pixel position from sync/de and measures line, frame and active-area timing with lock detection.
module video_timing_rx #(
    parameter int CW          = 12,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          clk_pix,
    input  logic          rst_pix_n,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          de,
    output logic [CW-1:0] o_sx,
    output logic [CW-1:0] o_sy,
    output logic          o_de,
    output logic [CW-1:0] o_line_len,
    output logic [CW-1:0] o_frame_lines,
    output logic [CW-1:0] o_act_w,
    output logic [CW-1:0] o_act_h,
    output logic          o_frame_start,
    output logic          o_locked,
    output logic          o_err
);
    localparam logic [CW-1:0] MAX  = '1;
    localparam logic [3:0]    LOCK = 4'(LOCK_FRAMES);

    logic          hs_q, vs_q, de_q;
    logic [CW-1:0] hcnt, vcnt, cur_len;
    logic          line_seen, len_v, line_ok, armed, prev_v;
    logic [3:0]    good_cnt, good_nxt;
    logic          hs_fall, vs_fall, de_rise, de_fall, len_bad, timeout, frame_good;

    always_comb begin
        hs_fall    = hs_q & ~hsync;
        vs_fall    = vs_q & ~vsync;
        de_rise    = de & ~de_q;
        de_fall    = ~de & de_q;
        cur_len    = hcnt + 1'b1;
        len_bad    = hs_fall & line_seen & len_v & (cur_len != o_line_len);
        timeout    = ~hs_fall & (hcnt == MAX - 1'b1);
        frame_good = line_ok & ~len_bad & armed & prev_v & (vcnt == o_frame_lines);
        good_nxt   = (good_cnt == LOCK) ? LOCK : good_cnt + 4'd1;
    end

    // armed: a vsync fall has been seen, so the next captured frame count is a whole frame.
    // prev_v: o_frame_lines holds a whole-frame count and can serve as the stability reference.
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            de_q          <= 1'b0;
            hcnt          <= '0;
            vcnt          <= '0;
            line_seen     <= 1'b0;
            len_v         <= 1'b0;
            line_ok       <= 1'b1;
            armed         <= 1'b0;
            prev_v        <= 1'b0;
            good_cnt      <= '0;
            o_sx          <= '0;
            o_sy          <= '0;
            o_de          <= 1'b0;
            o_line_len    <= '0;
            o_frame_lines <= '0;
            o_act_w       <= '0;
            o_act_h       <= '0;
            o_frame_start <= 1'b0;
            o_locked      <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            hs_q          <= hsync;
            vs_q          <= vsync;
            de_q          <= de;
            o_de          <= de;
            o_frame_start <= vs_fall;
            o_err         <= 1'b0;
            if (hs_fall) begin
                if (line_seen) begin
                    o_line_len <= cur_len;
                    len_v      <= 1'b1;
                end
                line_seen <= 1'b1;
                hcnt      <= '0;
            end else if (hcnt != MAX) begin
                hcnt <= hcnt + 1'b1;
            end
            if (len_bad)
                line_ok <= 1'b0;
            if (vs_fall) begin
                o_frame_lines <= vcnt;
                o_act_h       <= o_sy;
                vcnt          <= CW'(hs_fall);
                o_sy          <= '0;
                line_ok       <= 1'b1;
                len_v         <= 1'b0;
                armed         <= 1'b1;
                prev_v        <= armed;
                if (frame_good) begin
                    good_cnt <= good_nxt;
                    o_locked <= (good_nxt == LOCK);
                end else begin
                    good_cnt <= '0;
                    o_locked <= 1'b0;
                    o_err    <= prev_v;
                end
            end else begin
                if (hs_fall && vcnt != MAX)
                    vcnt <= vcnt + 1'b1;
                if (de_fall && o_sy != MAX)
                    o_sy <= o_sy + 1'b1;
            end
            if (de_rise)
                o_sx <= '0;
            else if (de && o_sx != MAX)
                o_sx <= o_sx + 1'b1;
            if (de_fall)
                o_act_w <= (o_sx == MAX) ? MAX : o_sx + 1'b1;
            // a lost hsync invalidates everything measured so far, so relock starts from scratch
            if (timeout) begin
                o_locked  <= 1'b0;
                good_cnt  <= '0;
                line_seen <= 1'b0;
                armed     <= 1'b0;
                prev_v    <= 1'b0;
                o_err     <= 1'b1;
            end
        end
    end
endmodule
